// File: rtl/fetch_pc_predict.sv
// Fetch-stage PC selection and next-PC prediction with a circular return-address stack.
// Misprediction corrections from the memory and writeback stages override the predicted PC.
module fetch_pc_predict #(
  parameter int                  WORD_W    = 32,
  parameter int                  RAS_DEPTH = 4,
  parameter logic [WORD_W-1:0]   RESET_PC  = '0,
  parameter logic [7:0]          IJXX      = 8'h07,
  parameter logic [7:0]          ICALL     = 8'h08,
  parameter logic [7:0]          IRET      = 8'h09
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         F_stall_i,
  input  logic                         f_valid_i,
  input  logic [7:0]                   f_icode_i,
  input  logic [WORD_W-1:0]            f_valC_i,
  input  logic [WORD_W-1:0]            f_valP_i,
  input  logic [7:0]                   M_icode_i,
  input  logic                         M_Cnd_i,
  input  logic [WORD_W-1:0]            M_valA_i,
  input  logic [7:0]                   W_icode_i,
  input  logic [WORD_W-1:0]            W_valM_i,
  input  logic [WORD_W-1:0]            W_retpred_i,
  output logic [WORD_W-1:0]            f_pc_o,
  output logic [WORD_W-1:0]            f_predPC_o,
  output logic [WORD_W-1:0]            f_retpred_o,
  output logic                         f_redirect_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);

  logic [WORD_W-1:0] pred_pc_reg;
  logic [PW-1:0]     ras_ptr_reg, ras_ptr_next;
  logic [CW-1:0]     ras_count_reg, ras_count_next;
  logic [WORD_W-1:0] ras_mem [RAS_DEPTH];

  logic              jxx_mispred, ret_mispred;
  logic              ras_nonempty;
  logic [WORD_W-1:0] ras_top;
  logic              load_pc, take_effect, do_push, do_pop;
  logic [PW-1:0]     base_ptr;
  logic [CW-1:0]     base_count;

  // Correction sources: not-taken branch first, then mispredicted return.
  always_comb begin
    jxx_mispred  = (M_icode_i == IJXX) && !M_Cnd_i;
    ret_mispred  = (W_icode_i == IRET) && (W_valM_i != W_retpred_i);
    f_redirect_o = jxx_mispred || ret_mispred;
    if (jxx_mispred)
      f_pc_o = M_valA_i;
    else if (ret_mispred)
      f_pc_o = W_valM_i;
    else
      f_pc_o = pred_pc_reg;
  end

  // The top of stack sits one below the write pointer.
  always_comb begin
    ras_nonempty = (ras_count_reg != '0);
    ras_top      = ras_mem[ras_ptr_reg - PW'(1)];
    f_retpred_o  = ras_nonempty ? ras_top : f_valP_i;
    if (f_valid_i && ((f_icode_i == IJXX) || (f_icode_i == ICALL)))
      f_predPC_o = f_valC_i;
    else if (f_valid_i && (f_icode_i == IRET) && ras_nonempty)
      f_predPC_o = ras_top;
    else
      f_predPC_o = f_valP_i;
  end

  always_comb begin
    load_pc     = !F_stall_i || f_redirect_o;
    take_effect = load_pc && f_valid_i;
    do_push     = take_effect && (f_icode_i == ICALL);
    do_pop      = take_effect && (f_icode_i == IRET);
  end

  // A redirect flushes the stack before this cycle's push/pop is applied,
  // so a pop on the flushed stack simply falls through.
  always_comb begin
    base_ptr       = f_redirect_o ? '0 : ras_ptr_reg;
    base_count     = f_redirect_o ? '0 : ras_count_reg;
    ras_ptr_next   = ras_ptr_reg;
    ras_count_next = ras_count_reg;
    if (load_pc) begin
      ras_ptr_next   = base_ptr;
      ras_count_next = base_count;
      if (do_push) begin
        ras_ptr_next   = base_ptr + PW'(1);
        ras_count_next = (base_count == COUNT_FULL) ? base_count : base_count + CW'(1);
      end else if (do_pop && (base_count != '0)) begin
        ras_ptr_next   = base_ptr - PW'(1);
        ras_count_next = base_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_pc_reg   <= RESET_PC;
      ras_ptr_reg   <= '0;
      ras_count_reg <= '0;
    end else begin
      if (load_pc)
        pred_pc_reg <= f_predPC_o;
      ras_ptr_reg   <= ras_ptr_next;
      ras_count_reg <= ras_count_next;
    end
  end

  // Entry storage needs no reset; only pointer and count qualify its contents.
  // When full, writing at the pointer overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (do_push)
      ras_mem[base_ptr] <= f_valP_i;
  end

  assign ras_count_o = ras_count_reg;

endmodule

// File: tb/tb_fetch_pc_predict.sv
// Scoreboard bench for fetch_pc_predict: a queue-based RAS model predicts every
// combinational output, plus directed checks of the documented scenarios.
module tb_fetch_pc_predict;
  localparam int W = 32;
  localparam int D = 4;
  localparam logic [7:0] INOP = 8'h01, IJXX = 8'h07, ICALL = 8'h08, IRET = 8'h09;

  logic         clk = 1'b0;
  logic         rst;
  logic         F_stall_i, f_valid_i, M_Cnd_i;
  logic [7:0]   f_icode_i, M_icode_i, W_icode_i;
  logic [W-1:0] f_valC_i, f_valP_i, M_valA_i, W_valM_i, W_retpred_i;
  logic [W-1:0] f_pc_o, f_predPC_o, f_retpred_o;
  logic         f_redirect_o;
  logic [2:0]   ras_count_o;

  fetch_pc_predict #(.WORD_W(W), .RAS_DEPTH(D), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .F_stall_i(F_stall_i), .f_valid_i(f_valid_i),
    .f_icode_i(f_icode_i), .f_valC_i(f_valC_i), .f_valP_i(f_valP_i),
    .M_icode_i(M_icode_i), .M_Cnd_i(M_Cnd_i), .M_valA_i(M_valA_i),
    .W_icode_i(W_icode_i), .W_valM_i(W_valM_i), .W_retpred_i(W_retpred_i),
    .f_pc_o(f_pc_o), .f_predPC_o(f_predPC_o), .f_retpred_o(f_retpred_o),
    .f_redirect_o(f_redirect_o), .ras_count_o(ras_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] pred;
    logic [W-1:0] retpred;
    logic         redir;
    logic [2:0]   cnt;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         cur;
  logic [W-1:0] pred_pc_m;
  logic [W-1:0] ras_m[$];
  int           total = 0;
  int           bad = 0;
  int           txn = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_mw();
    M_icode_i = INOP; M_Cnd_i = 1'b1; M_valA_i = '0;
    W_icode_i = INOP; W_valM_i = '0; W_retpred_i = '0;
  endtask

  task automatic model_reset();
    pred_pc_m = '0;
    ras_m.delete();
  endtask

  // Drive one cycle of fetch inputs, predict outputs, and compare via the queue.
  task automatic apply(input logic stall, input logic valid, input logic [7:0] icode,
                       input logic [W-1:0] valc, input logic [W-1:0] valp);
    exp_t e;
    logic [W-1:0] top;
    F_stall_i = stall; f_valid_i = valid; f_icode_i = icode;
    f_valC_i = valc; f_valP_i = valp;
    #1;
    top = (ras_m.size() > 0) ? ras_m[$] : '0;
    e.redir = ((M_icode_i == IJXX) && !M_Cnd_i) ||
              ((W_icode_i == IRET) && (W_valM_i != W_retpred_i));
    if ((M_icode_i == IJXX) && !M_Cnd_i)                      e.pc = M_valA_i;
    else if ((W_icode_i == IRET) && (W_valM_i != W_retpred_i)) e.pc = W_valM_i;
    else                                                       e.pc = pred_pc_m;
    if (valid && (icode == IJXX || icode == ICALL))           e.pred = valc;
    else if (valid && icode == IRET && ras_m.size() > 0)      e.pred = top;
    else                                                      e.pred = valp;
    e.retpred = (ras_m.size() > 0) ? top : valp;
    e.cnt = 3'(ras_m.size());
    exp_q.push_back(e);
    cur = e;
    e = exp_q.pop_front();
    txn++;
    $display("txn %0d pc=%0h pred=%0h cnt=%0d redir=%0b", txn, f_pc_o, f_predPC_o, ras_count_o, f_redirect_o);
    check("pc", f_pc_o, e.pc);
    check("predpc", f_predPC_o, e.pred);
    check("retpred", f_retpred_o, e.retpred);
    check("redirect", f_redirect_o, e.redir);
    check("count", ras_count_o, e.cnt);
  endtask

  // Clock edge: advance the reference model exactly as the block should.
  task automatic tick();
    logic load;
    @(posedge clk);
    load = !F_stall_i || cur.redir;
    if (load) pred_pc_m = cur.pred;
    if (cur.redir) ras_m.delete();
    if (load && f_valid_i) begin
      if (f_icode_i == ICALL) begin
        ras_m.push_back(f_valP_i);
        if (ras_m.size() > D) void'(ras_m.pop_front());
      end else if (f_icode_i == IRET && ras_m.size() > 0) begin
        void'(ras_m.pop_back());
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle_mw();
    F_stall_i = 1'b0; f_valid_i = 1'b0; f_icode_i = INOP; f_valC_i = '0; f_valP_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc", f_pc_o, 0);
    check("rst_cnt", ras_count_o, 0);
    rst = 1'b1;

    // Reset release, then call/ret pair
    apply(0, 1, INOP, 0, 32'h1);       check("r21_pc0", f_pc_o, 32'h0); tick();
    apply(0, 1, ICALL, 32'h40, 32'h9); check("r21_pc1", f_pc_o, 32'h1); tick();
    apply(0, 1, INOP, 0, 32'h41);      check("r22_pc", f_pc_o, 32'h40);
    check("r22_cnt1", ras_count_o, 1); tick();
    apply(0, 1, IRET, 0, 32'h42);      check("r22_retpred", f_predPC_o, 32'h9); tick();
    apply(0, 0, INOP, 0, 0);           check("r22_cnt0", ras_count_o, 0);
    check("r22_pcret", f_pc_o, 32'h9); tick();

    // Overflow: five calls into a four-deep stack
    for (int i = 1; i <= 5; i++) begin
      apply(0, 1, ICALL, 32'h100, W'(i * 16)); tick();
    end
    apply(0, 0, INOP, 0, 0); check("r23_full", ras_count_o, 4); tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, IRET, 0, 32'h200);
      check("r23_ret", f_predPC_o, W'((5 - i) * 16)); tick();
    end
    apply(0, 1, IRET, 0, 32'h299);
    check("r23_ret5", f_predPC_o, 32'h299); check("r23_cnt", ras_count_o, 0); tick();
    apply(0, 0, INOP, 0, 0); check("r23_cnt_after", ras_count_o, 0); tick();

    // Redirect while stalled loads the register and flushes the stack
    apply(0, 1, ICALL, 32'h300, 32'h55); tick();
    M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 32'h77;
    apply(1, 1, INOP, 0, 32'h78);
    check("r24_pc", f_pc_o, 32'h77); check("r24_redir", f_redirect_o, 1); tick();
    idle_mw();
    apply(1, 0, INOP, 0, 0);
    check("r24_cnt", ras_count_o, 0); check("r24_load", f_pc_o, 32'h78); tick();

    // Redirect plus call leaves exactly one entry
    apply(0, 1, ICALL, 32'h400, 32'h11); tick();
    apply(0, 1, ICALL, 32'h400, 32'h12); tick();
    M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 32'h80;
    apply(0, 1, ICALL, 32'h90, 32'h81); tick();
    idle_mw();
    apply(1, 0, INOP, 0, 0); check("redir_push_cnt", ras_count_o, 1);
    check("redir_push_pc", f_pc_o, 32'h90);
    check("redir_push_top", f_retpred_o, 32'h81); tick();

    // Stall without redirect changes nothing
    apply(1, 1, ICALL, 32'ha0, 32'h91); tick();
    apply(1, 1, IRET, 0, 32'h92);
    check("stall_cnt", ras_count_o, 1); check("stall_pc", f_pc_o, 32'h90); tick();

    // Branch correction beats return correction
    M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 32'h20;
    W_icode_i = IRET; W_valM_i = 32'h30; W_retpred_i = 32'h31;
    apply(1, 0, INOP, 0, 0); check("r25_pc", f_pc_o, 32'h20); tick();
    idle_mw();
    apply(0, 1, INOP, 0, 32'h5c); tick();
    W_icode_i = IRET; W_valM_i = 32'h9; W_retpred_i = 32'h9;
    apply(0, 0, INOP, 0, 0);
    check("r26_redir", f_redirect_o, 0); check("r26_pc", f_pc_o, 32'h5c); tick();
    W_icode_i = IRET; W_valM_i = 32'h33; W_retpred_i = 32'h9;
    apply(1, 0, INOP, 0, 0); check("ret_fix_pc", f_pc_o, 32'h33); tick();
    idle_mw();

    // Random traffic checked against the model
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ic;
      case ($urandom_range(0, 3))
        0: ic = INOP;
        1: ic = IJXX;
        2: ic = ICALL;
        default: ic = IRET;
      endcase
      M_icode_i = ($urandom_range(0, 9) == 0) ? IJXX : INOP;
      M_Cnd_i = 1'($urandom_range(0, 1));
      M_valA_i = $urandom;
      W_icode_i = ($urandom_range(0, 9) == 0) ? IRET : INOP;
      W_valM_i = $urandom;
      W_retpred_i = $urandom_range(0, 1) ? W_valM_i : $urandom;
      apply(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1) | ($urandom_range(0, 1))),
            ic, $urandom, $urandom);
      tick();
    end
    idle_mw();

    // Asynchronous reset mid-operation discards the stack
    apply(0, 1, ICALL, 32'h500, 32'h66); tick();
    apply(0, 1, ICALL, 32'h600, 32'h67); tick();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cnt", ras_count_o, 0);
    check("mid_rst_pc", f_pc_o, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(0, 1, INOP, 0, 32'h4); check("post_rst_pc", f_pc_o, 0); tick();
    apply(0, 1, IRET, 0, 32'h8); check("post_rst_ret", f_predPC_o, 32'h8); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
